// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: ALU control codes, flag positions, opcodes,
// controller states and flag write masks.
package alu_pkg;

  localparam logic [2:0] AluSum = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluXor = 3'b010;
  localparam logic [2:0] AluAnd = 3'b011;
  localparam logic [2:0] AluSr  = 3'b100;

  localparam int unsigned FlagNeg   = 7;
  localparam int unsigned FlagOvf   = 6;
  localparam int unsigned FlagDec   = 3;
  localparam int unsigned FlagZero  = 1;
  localparam int unsigned FlagCarry = 0;

  localparam logic [2:0] OpAdc = 3'd0;
  localparam logic [2:0] OpSbc = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOra = 3'd3;
  localparam logic [2:0] OpEor = 3'd4;
  localparam logic [2:0] OpLsr = 3'd5;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StExec  = 3'd1;
  localparam logic [2:0] StAdjLo = 3'd2;
  localparam logic [2:0] StAdjHi = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [7:0] WeArith = 8'hC3;
  localparam logic [7:0] WeLogic = 8'h82;
  localparam logic [7:0] WeShift = 8'h83;
  localparam logic [7:0] WeNone  = 8'h00;

  function automatic logic [7:0] flags_we_mask(input logic [2:0] op);
    case (op)
      OpAdc, OpSbc:        return WeArith;
      OpAnd, OpOra, OpEor: return WeLogic;
      OpLsr:               return WeShift;
      default:             return WeNone;
    endcase
  endfunction

  function automatic logic [7:0] pack_flags(input logic n, input logic v, input logic d,
                                            input logic z, input logic c);
    logic [7:0] f;
    f            = 8'h00;
    f[FlagNeg]   = n;
    f[FlagOvf]   = v;
    f[FlagDec]   = d;
    f[FlagZero]  = z;
    f[FlagCarry] = c;
    return f;
  endfunction

  function automatic logic [4:0] nib_sum(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {4'b0000, c};
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/V/Z derivation from ALU operands and result.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [7:0] ai,
  input  logic [7:0] bi,
  input  logic [7:0] y,
  output logic       n,
  output logic       v,
  output logic       z
);

  assign n = y[7];
  assign z = (y == 8'h00);
  // Overflow: operands agree in sign but the result does not.
  assign v = (ai[7] == bi[7]) && (y[7] != ai[7]);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller around the external combinational ALU.
// Decimal correction passes are built only when ALU_SEQ_BCD_EN is defined.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_c,
  input  logic       req_d,
  output logic [2:0] alu_ctrl,
  output logic [7:0] alu_AI,
  output logic [7:0] alu_BI,
  output logic       alu_carry,
  output logic       alu_BCD,
  input  logic [7:0] alu_Y,
  input  logic [7:0] alu_flags,
  output logic       done,
  output logic [7:0] res,
  output logic [7:0] flags,
  output logic [7:0] flags_we
);

  logic [2:0] state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q;
  logic       cin_q;
  logic [7:0] res_q, flags_q, flags_we_q;

  logic       fg_n, fg_v, fg_z;
  logic       op_legal, is_adc, is_sbc, dec_op, d_bit, c_exec;
  logic [7:0] y_exec;

  assign op_legal = (op_q <= OpLsr);
  assign is_adc   = (op_q == OpAdc);
  assign is_sbc   = (op_q == OpSbc);
  assign y_exec   = op_legal ? alu_Y : a_q;
  assign c_exec   = (op_q == OpLsr) ? a_q[0] : alu_flags[0];

`ifdef ALU_SEQ_BCD_EN
  logic       d_q, c_q, n_q, v_q, z_q;
  logic [7:0] y_q;
  logic [4:0] lo_adc, lo_sbc;
  logic [7:0] adj_lo_val, adj_hi_val;
  logic       unused_flags;

  assign unused_flags = ^alu_flags[7:1];
  assign lo_adc       = nib_sum(a_q[3:0], b_q[3:0], cin_q);
  assign lo_sbc       = nib_sum(a_q[3:0], ~b_q[3:0], cin_q);
  assign dec_op       = d_q && (is_adc || is_sbc);
  assign d_bit        = d_q;

  // Corrections are always applied (possibly as zero) so decimal latency is fixed.
  always_comb begin
    adj_lo_val = 8'h00;
    adj_hi_val = 8'h00;
    if (is_adc) begin
      adj_lo_val = (lo_adc > 5'd9) ? 8'h06 : 8'h00;
      adj_hi_val = (c_q || (y_q[7:4] > 4'd9)) ? 8'h60 : 8'h00;
    end else if (is_sbc) begin
      adj_lo_val = (lo_sbc < 5'd16) ? 8'hFA : 8'h00;
      adj_hi_val = c_q ? 8'h00 : 8'hA0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
      c_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
      y_q <= 8'h00;
    end else begin
      case (state_q)
        StIdle: if (req_valid) d_q <= req_d;
        StExec: begin
          y_q <= y_exec;
          c_q <= c_exec;
          n_q <= fg_n;
          v_q <= fg_v;
          z_q <= fg_z;
        end
        StAdjLo: begin
          y_q <= alu_Y;
          if (is_adc) c_q <= c_q | alu_flags[0];
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_in;

  assign unused_in = ^{alu_flags[7:1], req_d};
  assign dec_op    = 1'b0;
  assign d_bit     = 1'b0;
`endif

  alu_flag_gen u_flag_gen (
    .ai (alu_AI),
    .bi (alu_BI),
    .y  (alu_Y),
    .n  (fg_n),
    .v  (fg_v),
    .z  (fg_z)
  );

  always_comb begin
    alu_ctrl  = AluSum;
    alu_AI    = 8'h00;
    alu_BI    = 8'h00;
    alu_carry = 1'b0;
    case (state_q)
      StExec: begin
        alu_AI = a_q;
        case (op_q)
          OpAdc: begin
            alu_BI    = b_q;
            alu_carry = cin_q;
          end
          OpSbc: begin
            alu_BI    = ~b_q;
            alu_carry = cin_q;
          end
          OpAnd: begin
            alu_ctrl = AluAnd;
            alu_BI   = b_q;
          end
          OpOra: begin
            alu_ctrl = AluOr;
            alu_BI   = b_q;
          end
          OpEor: begin
            alu_ctrl = AluXor;
            alu_BI   = b_q;
          end
          OpLsr:   alu_ctrl = AluSr;
          default: ;
        endcase
      end
`ifdef ALU_SEQ_BCD_EN
      StAdjLo: begin
        alu_AI = y_q;
        alu_BI = adj_lo_val;
      end
      StAdjHi: begin
        alu_AI = y_q;
        alu_BI = adj_hi_val;
      end
`endif
      default: ;
    endcase
  end

  assign alu_BCD = 1'b0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (req_valid) state_d = StExec;
      StExec: state_d = dec_op ? StAdjLo : StDone;
`ifdef ALU_SEQ_BCD_EN
      StAdjLo: state_d = StAdjHi;
      StAdjHi: state_d = StDone;
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= 3'd0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      cin_q      <= 1'b0;
      res_q      <= 8'h00;
      flags_q    <= 8'h00;
      flags_we_q <= 8'h00;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            cin_q <= req_c;
          end
        end
        StExec: begin
          if (!dec_op) begin
            res_q      <= y_exec;
            flags_q    <= pack_flags(fg_n, fg_v, d_bit, fg_z, c_exec);
            flags_we_q <= flags_we_mask(op_q);
          end
        end
`ifdef ALU_SEQ_BCD_EN
        // N/V/Z keep the binary result; only the value and carry are corrected.
        StAdjHi: begin
          res_q      <= alu_Y;
          flags_q    <= pack_flags(n_q, v_q, d_q, z_q,
                                   is_adc ? (c_q | (adj_hi_val != 8'h00)) : c_q);
          flags_we_q <= WeArith;
        end
`endif
        default: ;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign done      = (state_q == StDone);
  assign res       = res_q;
  assign flags     = flags_q;
  assign flags_we  = flags_we_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the external ALU.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic       req_c = 1'b0;
  logic       req_d = 1'b0;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_AI, alu_BI;
  logic       alu_carry, alu_BCD;
  logic [7:0] alu_Y, alu_flags;
  logic       done;
  logic [7:0] res, flags, flags_we;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_d     (req_d),
    .alu_ctrl  (alu_ctrl),
    .alu_AI    (alu_AI),
    .alu_BI    (alu_BI),
    .alu_carry (alu_carry),
    .alu_BCD   (alu_BCD),
    .alu_Y     (alu_Y),
    .alu_flags (alu_flags),
    .done      (done),
    .res       (res),
    .flags     (flags),
    .flags_we  (flags_we)
  );

  // External ALU model: SUM 000, OR 001, XOR 010, AND 011, SR 100; carry out on bit 0.
  logic [8:0] sum9;
  always_comb begin
    sum9      = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'h00, alu_carry};
    alu_Y     = 8'h00;
    alu_flags = 8'h00;
    case (alu_ctrl)
      3'b000: begin
        alu_Y        = sum9[7:0];
        alu_flags[0] = sum9[8];
      end
      3'b001:  alu_Y = alu_AI | alu_BI;
      3'b010:  alu_Y = alu_AI ^ alu_BI;
      3'b011:  alu_Y = alu_AI & alu_BI;
      3'b100:  alu_Y = {1'b0, alu_AI[7:1]};
      default: alu_Y = 8'h00;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       d;
    logic [2:0] ctrl;
    logic [7:0] res;
    logic [7:0] flg;
    logic [7:0] we;
    int         lat;
  } vec_t;

  localparam int NumVec = 15;
  vec_t vecs[NumVec];

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic c, input logic d, input logic [2:0] ctrl,
                              input logic [7:0] r, input logic [7:0] flg,
                              input logic [7:0] we, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.d = d; v.ctrl = ctrl;
    v.res = r; v.flg = flg; v.we = we; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // lat = negedges from the accept edge to the first sample showing done.
  task automatic run_req(input vec_t v, input string tag);
    int n;
    logic got;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_op = v.op; req_a = v.a; req_b = v.b; req_c = v.c; req_d = v.d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".ctrl"}, {29'd0, alu_ctrl}, {29'd0, v.ctrl});
    check({tag, ".ai"}, {24'd0, alu_AI}, {24'd0, v.a});
    check({tag, ".busy"}, {31'd0, req_ready}, 32'd0);
    n = 1;
    got = done;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = done;
    end
    check({tag, ".lat"}, n, v.lat);
    check({tag, ".res"}, {24'd0, res}, {24'd0, v.res});
    check({tag, ".flags"}, {24'd0, flags & v.we}, {24'd0, v.flg});
    check({tag, ".we"}, {24'd0, flags_we}, {24'd0, v.we});
    @(negedge clk);
    check({tag, ".pulse"}, {31'd0, done}, 32'd0);
    check({tag, ".hold"}, {24'd0, res}, {24'd0, v.res});
  endtask

`ifdef ALU_SEQ_BCD_EN
  localparam int DecLat = 4;
`else
  localparam int DecLat = 2;
`endif

  int idx, first_done, second_done, rdy_idx, seen_done;
  logic [7:0] res1, res2;

  initial begin
    vecs[0]  = mk(3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 3'd0, 8'hA0, 8'hC0, 8'hC3, 2);
    vecs[1]  = mk(3'd1, 8'h00, 8'h01, 1'b1, 1'b0, 3'd0, 8'hFF, 8'h80, 8'hC3, 2);
    vecs[2]  = mk(3'd5, 8'h01, 8'hAA, 1'b0, 1'b0, 3'd4, 8'h00, 8'h03, 8'h83, 2);
    vecs[3]  = mk(3'd2, 8'hF0, 8'h3C, 1'b0, 1'b0, 3'd3, 8'h30, 8'h00, 8'h82, 2);
    vecs[4]  = mk(3'd3, 8'h80, 8'h01, 1'b0, 1'b0, 3'd1, 8'h81, 8'h80, 8'h82, 2);
    vecs[5]  = mk(3'd4, 8'h5A, 8'h5A, 1'b1, 1'b0, 3'd2, 8'h00, 8'h02, 8'h82, 2);
    vecs[6]  = mk(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00, 8'h03, 8'hC3, 2);
    vecs[7]  = mk(3'd0, 8'h7F, 8'h00, 1'b1, 1'b0, 3'd0, 8'h80, 8'hC0, 8'hC3, 2);
    vecs[8]  = mk(3'd1, 8'h80, 8'h01, 1'b1, 1'b0, 3'd0, 8'h7F, 8'h41, 8'hC3, 2);
    vecs[9]  = mk(3'd6, 8'h5A, 8'h11, 1'b1, 1'b0, 3'd0, 8'h5A, 8'h00, 8'h00, 2);
    vecs[10] = mk(3'd7, 8'hC3, 8'h01, 1'b0, 1'b0, 3'd0, 8'hC3, 8'h00, 8'h00, 2);
`ifdef ALU_SEQ_BCD_EN
    vecs[11] = mk(3'd0, 8'h19, 8'h28, 1'b0, 1'b1, 3'd0, 8'h47, 8'h00, 8'hC3, DecLat);
    vecs[12] = mk(3'd0, 8'h99, 8'h01, 1'b0, 1'b1, 3'd0, 8'h00, 8'h81, 8'hC3, DecLat);
    vecs[13] = mk(3'd1, 8'h50, 8'h01, 1'b1, 1'b1, 3'd0, 8'h49, 8'h01, 8'hC3, DecLat);
    vecs[14] = mk(3'd1, 8'h10, 8'h20, 1'b1, 1'b1, 3'd0, 8'h90, 8'h80, 8'hC3, DecLat);
`else
    // Decimal flag is ignored: plain binary results.
    vecs[11] = mk(3'd0, 8'h19, 8'h28, 1'b0, 1'b1, 3'd0, 8'h41, 8'h00, 8'hC3, DecLat);
    vecs[12] = mk(3'd0, 8'h99, 8'h01, 1'b0, 1'b1, 3'd0, 8'h9A, 8'h80, 8'hC3, DecLat);
    vecs[13] = mk(3'd1, 8'h50, 8'h01, 1'b1, 1'b1, 3'd0, 8'h4F, 8'h01, 8'hC3, DecLat);
    vecs[14] = mk(3'd1, 8'h10, 8'h20, 1'b1, 1'b1, 3'd0, 8'hF0, 8'h80, 8'hC3, DecLat);
`endif

    // Reset state.
    #12;
    check("rst.res", {24'd0, res}, 32'd0);
    check("rst.flags", {24'd0, flags}, 32'd0);
    check("rst.we", {24'd0, flags_we}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.alu", {alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < NumVec; i++) begin
      run_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back with req_valid held: the ORA presented during EXEC must wait for IDLE.
    first_done = 0; second_done = 0; rdy_idx = 0; res1 = 8'h00; res2 = 8'h00;
    req_valid = 1'b1; req_op = 3'd2; req_a = 8'hF0; req_b = 8'h3C; req_c = 1'b0; req_d = 1'b0;
    @(posedge clk);
    for (idx = 1; idx <= 10; idx++) begin
      @(negedge clk);
      if (idx == 1) begin
        req_op = 3'd3; req_a = 8'h0F; req_b = 8'h30;
      end
      if (req_ready && rdy_idx == 0) rdy_idx = idx;
      if (done && first_done == 0) begin
        first_done = idx;
        res1 = res;
      end else if (done && second_done == 0) begin
        second_done = idx;
        res2 = res;
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    check("b2b.done1", first_done, 2);
    check("b2b.res1", {24'd0, res1}, 32'h30);
    check("b2b.ready", rdy_idx, 3);
    check("b2b.done2", second_done, 5);
    check("b2b.res2", {24'd0, res2}, 32'h3F);
    @(negedge clk);
    @(negedge clk);

    // Reset during EXEC abandons the request.
    req_valid = 1'b1; req_op = 3'd0; req_a = 8'h12; req_b = 8'h34; req_c = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid.exec_ai", {24'd0, alu_AI}, 32'h12);
    rst_n = 1'b0;
    #1;
    check("mid.res", {24'd0, res}, 32'd0);
    check("mid.flags", {16'd0, flags, flags_we}, 32'd0);
    check("mid.alu", {alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD}, 32'd0);
    seen_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("mid.ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("mid.no_done", seen_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
